// File: rtl/dec16_timer_pkg.sv
// Shared types and constants for the dec16 countdown timer.
// Imported by the decrementer and the timer top.
package dec16_timer_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] ALL_ONES = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dec16.sv
// Combinational 16-bit wrapping decrementer.
// Adding all-ones drops the carry and yields a-1 mod 2^16.
module dec16
  import dec16_timer_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out
);

  assign out = a + ALL_ONES;

endmodule

// File: rtl/dec16_timer.sv
// Loadable down-counter with expiry pulse and auto-reload.
// Free-runs as a wrapping decrementer while idle.
module dec16_timer #(
  parameter int WIDTH = dec16_timer_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload_mode,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             expire,
  output logic             busy
);

  import dec16_timer_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] dec_out;
  logic             at_one;
  logic             can_reload;

  dec16 u_dec (
    .a   (out),
    .out (dec_out)
  );

  assign at_one     = (out == WIDTH'(1));
  assign can_reload = reload_mode && (reload_reg != '0);
  assign zero       = (out == '0);
  assign busy       = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out        <= '0;
      reload_reg <= '0;
      expire     <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (clear) begin
        state <= IDLE;
      end else if (load) begin
        out        <= load_val;
        reload_reg <= load_val;
        if (load_val != '0) begin
          state <= RUN;
        end else begin
          state  <= DONE;
          expire <= 1'b1;
        end
      end else if (en) begin
        unique case (1'b1)
          (state == IDLE): begin
            out <= dec_out;
          end
          (state == RUN): begin
            // Never decrement through zero while running.
            if (at_one) begin
              expire <= 1'b1;
              if (can_reload) begin
                out <= reload_reg;
              end else begin
                out   <= '0;
                state <= DONE;
              end
            end else if (!zero) begin
              out <= dec_out;
            end
          end
          (state == DONE): begin
            out <= out;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec16_timer.sv
// Directed self-checking bench for dec16_timer.
// Outputs are sampled 1ns after each rising edge.
module tb_dec16_timer;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        reload_mode;
  logic        clear;
  logic [15:0] out;
  logic        zero;
  logic        expire;
  logic        busy;

  int n_checks;
  int n_fail;
  int n_exp;

  dec16_timer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .reload_mode (reload_mode),
    .clear       (clear),
    .out         (out),
    .zero        (zero),
    .expire      (expire),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [15:0] o,
                        input logic e,
                        input logic b);
    chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".expire"}, 32'(expire), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    load        = 1'b0;
    load_val    = 16'h0;
    en          = 1'b0;
    reload_mode = 1'b0;
    clear       = 1'b0;

    // Reset and idle wrap
    step();
    step();
    chk_st("rst", 16'h0000, 1'b0, 1'b0);
    chk("rst.zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    chk_st("idle1", 16'hFFFF, 1'b0, 1'b0);
    chk("idle1.zero", 32'(zero), 32'd0);
    step();
    chk_st("idle2", 16'hFFFE, 1'b0, 1'b0);

    // One-shot countdown
    load     = 1'b1;
    load_val = 16'd3;
    step();
    chk_st("os_ld", 16'd3, 1'b0, 1'b1);
    load = 1'b0;
    step();
    chk_st("os_2", 16'd2, 1'b0, 1'b1);
    step();
    chk_st("os_1", 16'd1, 1'b0, 1'b1);
    step();
    chk_st("os_0", 16'd0, 1'b1, 1'b0);
    chk("os_0.zero", 32'(zero), 32'd1);
    step();
    chk_st("os_done", 16'd0, 1'b0, 1'b0);

    // Auto-reload
    reload_mode = 1'b1;
    load        = 1'b1;
    load_val    = 16'd2;
    step();
    chk_st("ar_ld", 16'd2, 1'b0, 1'b1);
    load  = 1'b0;
    n_exp = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar.out", 32'(out), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("ar.busy", 32'(busy), 32'd1);
      if (expire) n_exp++;
    end
    chk("ar.pulses", 32'(n_exp), 32'd3);

    // Zero load
    reload_mode = 1'b0;
    load        = 1'b1;
    load_val    = 16'd0;
    step();
    chk_st("z_ld", 16'd0, 1'b1, 1'b0);
    load = 1'b0;
    step();
    chk_st("z_hold", 16'd0, 1'b0, 1'b0);

    // Full-range countdown
    load     = 1'b1;
    load_val = 16'hFFFF;
    step();
    chk_st("max_ld", 16'hFFFF, 1'b0, 1'b1);
    load  = 1'b0;
    n_exp = 0;
    for (int i = 0; i < 65534; i++) begin
      step();
      if (expire) n_exp++;
    end
    chk("max.early", 32'(n_exp), 32'd0);
    chk_st("max_pre", 16'd1, 1'b0, 1'b1);
    step();
    chk_st("max_exp", 16'd0, 1'b1, 1'b0);
    step();
    chk_st("max_post", 16'd0, 1'b0, 1'b0);

    // Hold, clear, idle resumes decrementing
    load     = 1'b1;
    load_val = 16'd8;
    step();
    load = 1'b0;
    step();
    step();
    step();
    chk_st("cl_5", 16'd5, 1'b0, 1'b1);
    en = 1'b0;
    step();
    chk_st("cl_hold", 16'd5, 1'b0, 1'b1);
    en    = 1'b1;
    clear = 1'b1;
    step();
    chk_st("cl_clr", 16'd5, 1'b0, 1'b0);
    clear = 1'b0;
    step();
    chk_st("cl_idle", 16'd4, 1'b0, 1'b0);

    // Load beats expiry
    load     = 1'b1;
    load_val = 16'd2;
    step();
    load = 1'b0;
    step();
    chk_st("lw_1", 16'd1, 1'b0, 1'b1);
    load     = 1'b1;
    load_val = 16'd7;
    step();
    chk_st("lw_ld", 16'd7, 1'b0, 1'b1);
    load = 1'b0;

    // Reset mid-countdown
    load     = 1'b1;
    load_val = 16'd100;
    step();
    chk_st("mr_ld", 16'd100, 1'b0, 1'b1);
    load        = 1'b0;
    reload_mode = 1'b1;
    rst_n       = 1'b0;
    step();
    chk_st("mr_rst", 16'd0, 1'b0, 1'b0);
    chk("mr.reload_reg", 32'(dut.reload_reg), 32'd0);
    chk("mr.zero", 32'(zero), 32'd1);
    rst_n = 1'b1;
    step();
    chk_st("mr_idle", 16'hFFFF, 1'b0, 1'b0);
    load     = 1'b1;
    load_val = 16'd1;
    step();
    chk_st("mr_ld1", 16'd1, 1'b0, 1'b1);
    load = 1'b0;
    step();
    chk_st("mr_rel", 16'd1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
